grid_reader: RTL

GRID_READER -- requirements
Module: grid_reader

---
 rtl/grid_pkg.sv | 16 +
 rtl/grid_scan_counter.sv | 43 ++++
 rtl/grid_reader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared grid geometry and reader FSM encoding for grid_reader and its scan counter.
package grid_pkg;

  localparam int GRID_SIZE  = 28;
  localparam int GRID_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int ADDR_W     = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/grid_scan_counter.sv
// Row-major x/y/index stepper: index advances by one per step, x wraps into y.
// The linear index is carried alongside x/y so no multiplier is ever needed.
module grid_scan_counter #(
  parameter int GRID_SIZE = grid_pkg::GRID_SIZE
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        step,
  output logic [grid_pkg::ADDR_W-1:0] x,
  output logic [grid_pkg::ADDR_W-1:0] y,
  output logic [grid_pkg::ADDR_W-1:0] index,
  output logic                        last
);
  import grid_pkg::*;

  localparam int                CELLS      = GRID_SIZE * GRID_SIZE;
  localparam logic [ADDR_W-1:0] X_MAX      = ADDR_W'(GRID_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(CELLS - 1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      index <= '0;
    end else if (clear) begin
      x     <= '0;
      y     <= '0;
      index <= '0;
    end else if (step) begin
      index <= index + ADDR_W'(1);
      if (x == X_MAX) begin
        x <= '0;
        y <= y + ADDR_W'(1);
      end else begin
        x <= x + ADDR_W'(1);
      end
    end
  end

  assign last = (index == LAST_INDEX);

endmodule

// File: rtl/grid_reader.sv
// grid_reader: scans a GRID_SIZE x GRID_SIZE bit memory once per start and streams each cell as a pixel byte.
// Define GRID_READER_INK_COUNT_EN to build the set-cell counter on ink_count; otherwise it is tied to 0.
module grid_reader #(
  parameter int         GRID_SIZE = grid_pkg::GRID_SIZE,
  parameter logic [7:0] PIXEL_ON  = 8'd255,
  parameter logic [7:0] PIXEL_OFF = 8'd0
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd,
  output logic [grid_pkg::ADDR_W-1:0] mem_addr,
  input  logic                        mem_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic [grid_pkg::ADDR_W-1:0] out_index,
  output logic                        out_last,
  output logic [grid_pkg::ADDR_W-1:0] ink_count
);
  import grid_pkg::*;

  state_t            state_reg;
  logic              accept;
  logic              handshake;
  logic              scan_clear;
  logic              scan_step;
  logic              scan_last;
  logic [ADDR_W-1:0] scan_x;
  logic [ADDR_W-1:0] scan_y;
  logic [ADDR_W-1:0] scan_index;
  logic              unused_xy;

  // abort wins over a simultaneous handshake, so it masks both the step and the ink increment
  assign accept     = (state_reg == IDLE) && start;
  assign handshake  = (state_reg == SEND) && out_ready && !abort;
  assign scan_clear = accept;
  assign scan_step  = handshake && !out_last;
  assign mem_addr   = scan_index;
  assign unused_xy  = ^{scan_x, scan_y};

  grid_scan_counter #(
    .GRID_SIZE(GRID_SIZE)
  ) u_scan (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (scan_clear),
    .step    (scan_step),
    .x       (scan_x),
    .y       (scan_y),
    .index   (scan_index),
    .last    (scan_last)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg != IDLE && abort) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
        mem_rd    <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: if (start) begin
            state_reg <= READ;
            busy      <= 1'b1;
            mem_rd    <= 1'b1;
          end
          READ: begin
            mem_rd    <= 1'b0;
            state_reg <= WAIT;
          end
          WAIT: begin
            out_data  <= mem_data ? PIXEL_ON : PIXEL_OFF;
            out_index <= scan_index;
            out_last  <= scan_last;
            out_valid <= 1'b1;
            state_reg <= SEND;
          end
          SEND: if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= READ;
              mem_rd    <= 1'b1;
            end
          end
          DONE: begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef GRID_READER_INK_COUNT_EN
  logic [ADDR_W-1:0] ink_reg;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ink_reg <= '0;
    end else if (accept) begin
      ink_reg <= '0;
    end else if (handshake && out_data == PIXEL_ON) begin
      ink_reg <= ink_reg + ADDR_W'(1);
    end
  end

  assign ink_count = ink_reg;
`else
  assign ink_count = '0;
`endif

endmodule
